// File: rtl/grid_loader.sv
`default_nettype none
// ============================================================================
// Module   : grid_loader
// Purpose  : Packs an ASCII roll-grid stream into TX_W-bit occupancy chunks
//            ('@' -> 1) and writes them into the mem bank via write/ack/busy.
// Revision : 1.0
// ============================================================================

`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 8
`endif
`ifndef MAX_COLS
`define MAX_COLS 144
`endif
`ifndef BANK_DEPTH
`define BANK_DEPTH 140
`endif

module grid_loader #(
  parameter int TX_W     = `TX_DATA_WIDTH,
  parameter int ROW_W    = `BANK_ADDR_WIDTH,
  parameter int COL_W    = `COL_ADDR_WIDTH,
  parameter int MAX_COLS = `MAX_COLS,
  parameter int DEPTH    = `BANK_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             char_valid,
  input  logic [7:0]       char_in,
  input  logic             char_last,
  output logic             char_ready,
  output logic             write_en,
  output logic             pad_en,
  output logic [ROW_W-1:0] row_addr_out,
  output logic [COL_W-1:0] col_addr_out,
  output logic [TX_W-1:0]  partial_vec_out,
  input  logic             ack,
  input  logic             busy,
  output logic             done,
  output logic [ROW_W:0]   rows_loaded,
  output logic             err
);

  localparam int IW = (TX_W > 1) ? $clog2(TX_W) : 1;

  localparam logic [IW-1:0]    c_bidx_last = IW'(TX_W - 1);
  localparam logic [COL_W-1:0] c_max_cols  = COL_W'(MAX_COLS);
  localparam logic [COL_W-1:0] c_tx_step   = COL_W'(TX_W);
  localparam logic [ROW_W:0]   c_depth     = (ROW_W+1)'(DEPTH);
  localparam logic [7:0]       c_cr        = 8'h0D;
  localparam logic [7:0]       c_lf        = 8'h0A;
  localparam logic [7:0]       c_at        = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_WRITE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  logic [TX_W-1:0]  r_vec;
  logic [IW-1:0]    r_bidx;
  logic [COL_W-1:0] r_cbase;
  logic [ROW_W:0]   r_rows;
  logic             r_err;
  logic             r_fin;
  logic             r_ready;
  logic             r_write_en;
  logic             r_done;
  logic [ROW_W-1:0] r_wr_row;
  logic [COL_W-1:0] r_wr_col;
  logic [TX_W-1:0]  r_wr_data;

  logic             w_is_lf;
  logic             w_is_data;
  logic             w_drop;
  logic             w_take;
  logic [TX_W-1:0]  w_vec;
  logic             w_full;
  logic [IW-1:0]    w_nbidx;
  logic [COL_W-1:0] w_ncbase;
  logic [TX_W-1:0]  w_nvec;
  logic             w_row_ovf;
  logic             w_end;
  logic             w_write;
  logic             w_err;

  // Effect of the byte on char_in, assuming it is accepted this cycle.
  always_comb begin
    w_is_lf   = (char_in == c_lf);
    w_is_data = !w_is_lf && (char_in != c_cr);
    w_drop    = w_is_data && (r_cbase >= c_max_cols);
    w_take    = w_is_data && !w_drop;
    w_vec     = r_vec;
    for (int i = 0; i < TX_W; i++) begin
      if (w_take && (r_bidx == IW'(i))) w_vec[i] = (char_in == c_at);
    end
    w_full    = w_take && (r_bidx == c_bidx_last);
    w_nbidx   = w_full ? '0 : (w_take ? r_bidx + 1'b1 : r_bidx);
    w_ncbase  = w_full ? r_cbase + c_tx_step : r_cbase;
    w_nvec    = w_full ? '0 : w_vec;
    w_row_ovf = (r_rows >= c_depth);
    // A newline ends only a non-empty row; char_last closes whatever remains open.
    w_end     = w_is_lf ? ((r_bidx != '0) || (r_cbase != '0))
                        : (char_last && ((w_nbidx != '0) || (w_ncbase != '0)));
    w_write   = (w_full || (w_end && (w_nbidx != '0))) && !w_row_ovf;
    w_err     = w_drop || ((w_full || w_end) && w_row_ovf);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_vec      <= '0;
      r_bidx     <= '0;
      r_cbase    <= '0;
      r_rows     <= '0;
      r_err      <= 1'b0;
      r_fin      <= 1'b0;
      r_ready    <= 1'b0;
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_wr_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_ACCEPT;
            r_vec   <= '0;
            r_bidx  <= '0;
            r_cbase <= '0;
            r_rows  <= '0;
            r_err   <= 1'b0;
            r_fin   <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (char_valid) begin
            if (w_err) r_err <= 1'b1;
            if (w_write) begin
              r_wr_row  <= r_rows[ROW_W-1:0];
              r_wr_col  <= r_cbase;
              r_wr_data <= w_vec;
            end
            if (w_end) begin
              r_vec   <= '0;
              r_bidx  <= '0;
              r_cbase <= '0;
              if (!w_row_ovf) r_rows <= r_rows + 1'b1;
            end else begin
              r_vec   <= w_nvec;
              r_bidx  <= w_nbidx;
              r_cbase <= w_ncbase;
            end
            r_fin <= char_last;
            if (w_write) begin
              r_state    <= S_WRITE;
              r_ready    <= 1'b0;
              r_write_en <= 1'b1;
            end else if (char_last) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (ack) begin
            r_write_en <= 1'b0;
            if (busy) begin
              r_state <= S_RELEASE;
            end else if (r_fin) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ACCEPT;
              r_ready <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if (!ack) begin
            if (r_fin) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ACCEPT;
              r_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_ready    <= 1'b0;
          r_write_en <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready      = r_ready;
  assign write_en        = r_write_en;
  assign pad_en          = r_write_en;
  assign row_addr_out    = r_wr_row;
  assign col_addr_out    = r_wr_col;
  assign partial_vec_out = r_wr_data;
  assign done            = r_done;
  assign rows_loaded     = r_rows;
  assign err             = r_err;

endmodule

`default_nettype wire

// File: tb/tb_grid_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_loader
// Purpose  : Scoreboard bench for grid_loader with a handshake-driven mem model.
// Revision : 1.0
// ============================================================================

module tb_grid_loader;

  localparam int TX_W     = 8;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 5;
  localparam int MAX_COLS = 16;
  localparam int DEPTH    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             char_valid = 1'b0;
  logic [7:0]       char_in = 8'h00;
  logic             char_last = 1'b0;
  logic             char_ready;
  logic             write_en;
  logic             pad_en;
  logic [ROW_W-1:0] row_addr_out;
  logic [COL_W-1:0] col_addr_out;
  logic [TX_W-1:0]  partial_vec_out;
  logic             ack = 1'b0;
  logic             busy = 1'b0;
  logic             done;
  logic [ROW_W:0]   rows_loaded;
  logic             err;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [TX_W-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ack_wait = 0;
  int  busy_hold = 0;
  bit  no_ack = 1'b0;

  grid_loader #(
    .TX_W(TX_W), .ROW_W(ROW_W), .COL_W(COL_W), .MAX_COLS(MAX_COLS), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .char_valid(char_valid), .char_in(char_in), .char_last(char_last),
    .char_ready(char_ready), .write_en(write_en), .pad_en(pad_en),
    .row_addr_out(row_addr_out), .col_addr_out(col_addr_out),
    .partial_vec_out(partial_vec_out), .ack(ack), .busy(busy),
    .done(done), .rows_loaded(rows_loaded), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int r, input int c, input int d);
    wr_t e;
    e.row  = ROW_W'(r);
    e.col  = COL_W'(c);
    e.data = TX_W'(d);
    exp_q.push_back(e);
  endtask

  // Bank model: inputs change on the falling edge only.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("wr_row", 32'(row_addr_out), 32'(e.row));
          check("wr_col", 32'(col_addr_out), 32'(e.col));
          check("wr_data", 32'(partial_vec_out), 32'(e.data));
        end
        check("pad_en", 32'(pad_en), 32'(1));
        check("ready_in_write", 32'(char_ready), 32'(0));
        if (no_ack) begin
          for (int n = 0; n < 50 && write_en; n++) @(negedge clock);
        end else begin
          for (int n = 0; n < ack_wait; n++) begin
            @(negedge clock);
            check("we_hold", 32'(write_en), 32'(1));
          end
          ack  = 1'b1;
          busy = (busy_hold > 0);
          @(negedge clock);
          check("we_after_ack", 32'(write_en), 32'(0));
          for (int n = 0; n < busy_hold; n++) begin
            check("we_busy", 32'(write_en), 32'(0));
            check("ready_busy", 32'(char_ready), 32'(0));
            check("done_busy", 32'(done), 32'(0));
            @(negedge clock);
          end
          ack  = 1'b0;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_ready", 32'(char_ready), 32'(1));
    check("start_done", 32'(done), 32'(0));
    check("start_rows", 32'(rows_loaded), 32'(0));
    check("start_err", 32'(err), 32'(0));
  endtask

  task automatic send(input logic [7:0] c, input bit last);
    int n;
    n = 0;
    char_valid = 1'b1;
    char_in    = c;
    char_last  = last;
    while (!char_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(char_ready), 32'(1));
    @(negedge clock);
    char_valid = 1'b0;
    char_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic finish_load(input string tag, input int rows, input int e);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_rows"}, 32'(rows_loaded), 32'(rows));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_ready"}, 32'(char_ready), 32'(0));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check("rst_we", 32'(write_en), 32'(0));
    check("rst_ready", 32'(char_ready), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rows", 32'(rows_loaded), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_ready", 32'(char_ready), 32'(0));

    // Single partial chunk; write must follow the accepting edge directly.
    pulse_start();
    push_exp(0, 0, 8'h0D);
    send_str("@.@@", 1'b0);
    send(8'h0A, 1'b1);
    check("we_next_cycle", 32'(write_en), 32'(1));
    finish_load("t1", 1, 0);

    // Full chunk then partial, started from DONE.
    pulse_start();
    push_exp(0, 0, 8'hFF);
    push_exp(0, 8, 8'h02);
    send_str("@@@@@@@@.@\n", 1'b1);
    finish_load("t2", 1, 0);

    // Slow ack and busy retirement.
    ack_wait  = 5;
    busy_hold = 3;
    pulse_start();
    push_exp(0, 0, 8'h01);
    send_str("@\n", 1'b1);
    finish_load("t3", 1, 0);
    ack_wait  = 0;
    busy_hold = 0;

    // char_last closes an unterminated row; CR is ignored.
    pulse_start();
    push_exp(0, 0, 8'h01);
    push_exp(1, 0, 8'h02);
    send_str("@.\r\n.@", 1'b1);
    finish_load("t4", 2, 0);

    // Column overflow: 17th byte dropped.
    pulse_start();
    push_exp(0, 0, 8'hFF);
    push_exp(0, 8, 8'hFF);
    send_str("@@@@@@@@@@@@@@@@@\n", 1'b1);
    finish_load("t5", 1, 1);

    // Row overflow: fifth row discarded, count saturates.
    pulse_start();
    for (int r = 0; r < 4; r++) push_exp(r, 0, 8'h01);
    send_str("@\n\n@\n@\n@\n", 1'b0);
    check("t6_no_err_yet", 32'(err), 32'(0));
    send_str("@\n", 1'b1);
    finish_load("t6", 4, 1);

    // Reset while a write is outstanding.
    no_ack = 1'b1;
    pulse_start();
    push_exp(0, 0, 8'h01);
    send(8'h40, 1'b0);
    send(8'h0A, 1'b1);
    check("t7_we_before", 32'(write_en), 32'(1));
    #1 reset = 1'b0;
    #1;
    check("t7_we_async", 32'(write_en), 32'(0));
    check("t7_pad_async", 32'(pad_en), 32'(0));
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    no_ack = 1'b0;
    @(negedge clock);
    check("t7_done", 32'(done), 32'(0));
    check("t7_ready", 32'(char_ready), 32'(0));
    check("t7_rows", 32'(rows_loaded), 32'(0));
    pulse_start();
    push_exp(0, 0, 8'h03);
    send_str("@@\n", 1'b1);
    finish_load("t7", 1, 0);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/grid_loader.md
# grid_loader

Upstream load stage for the day-4 roll-grid flow. It accepts the puzzle input as an ASCII byte stream and packs each row into `TX_W`-bit occupancy chunks, with `'@'` → 1 and anything else → 0. It writes each chunk into the `mem` bank through that bank's write/ack/busy handshake, so the tile is fully populated before `freemachine` is started. It replaces bench-side loading; `done` is the point at which downstream may take the memory port.

## Interface
- `TX_W`, default `` `TX_DATA_WIDTH ``: chunk width, in bits and grid columns.
- `ROW_W`, default `` `BANK_ADDR_WIDTH ``: row address width.
- `COL_W`, default `` `COL_ADDR_WIDTH ``: column address width, in grid-column units.
- `MAX_COLS`, default `` `MAX_COLS ``: columns per row; must be a multiple of `TX_W`.
- `DEPTH`, default `` `BANK_DEPTH ``: rows in bank.
- `clock`  in  1: sole clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-low; 0 clears all state immediately.
- `start`  in  1: one-cycle pulse; begins a load from IDLE or DONE.
- `char_valid`  in  1: `char_in` is valid.
- `char_in`  in  8: ASCII byte.
- `char_last`  in  1: qualifies the final byte of the stream (sampled with `char_valid`).
- `char_ready`  out  1: loader accepts a byte this cycle.
- `write_en`  out  1: memory write request.
- `pad_en`  out  1: asserted identically to `write_en`.
- `row_addr_out`  out  `ROW_W`: write row.
- `col_addr_out`  out  `COL_W`: base column of chunk.
- `partial_vec_out`  out  `TX_W`: chunk data; bit i = column `col_addr_out`+i.
- `ack`  in  1: from `mem`; write accepted.
- `busy`  in  1: from `mem`; transaction still retiring.
- `done`  out  1: load complete; held until next `start`.
- `rows_loaded`  out  `ROW_W+1`: rows written this load.
- `err`  out  1: sticky; column or row overflow occurred.

## Operation
- States: IDLE, ACCEPT, WRITE, RELEASE, DONE.
  - IDLE →(start) ACCEPT. Clears vec, bit index `bidx`, chunk base `cbase`, row, `rows_loaded`, `err`.
  - ACCEPT: `char_ready`=1. On `char_valid`, classify the byte:
    - `'\r'`: ignored.
    - `'\n'`: if `bidx`>0 or `cbase`>0, end row; else blank line, ignored.
    - Other byte: `vec[bidx]` = (byte==`'@'`), `bidx`++.
  - Chunk full (`bidx` reaches `TX_W`): latch a write at (row, `cbase`), then `cbase`+=`TX_W`, `bidx`=0, vec cleared.
  - End row: if `bidx`>0, latch a write of the partial chunk (unused high bits 0). Then row++, `rows_loaded`++, `cbase`=0, `bidx`=0.
  - Any latched write → WRITE; otherwise stay in ACCEPT.
  - `char_last` on an accepted byte: process the byte, then end the row if it is non-empty. After the final write (or immediately if there is none) → DONE.
  - WRITE: `write_en`=`pad_en`=1; address and data stable. On the edge where `ack`=1: deassert. If `busy`=1 on that edge → RELEASE; else return to ACCEPT or DONE.
  - RELEASE: wait for `ack`=0, then ACCEPT or DONE.
  - DONE: `done`=1, `char_ready`=0; `start` → ACCEPT with fresh state.
- `start` outside IDLE/DONE: ignored.
- Overflow handling:
  - Data byte when `cbase` = `MAX_COLS`: dropped, `err`=1.
  - End row when row = `DEPTH`: no write, `err`=1, `rows_loaded` saturates at `DEPTH`.
- One write is outstanding at most; `char_ready`=0 from chunk completion until the write retires.

## Timing
- Reset values: all outputs 0; state IDLE.
- A byte is accepted on an edge with `char_valid`&`char_ready`.
- The completing byte's write appears the next cycle: `write_en`=1 one cycle after acceptance.
- `write_en` falls the cycle after `ack` is sampled 1. Minimum write occupancy is 1 cycle if `ack` is already high.
- Throughput with no chunk completion: 1 byte/cycle.
- `done` rises the cycle after the final write retires (`ack`=0 observed), or the cycle after the `char_last` byte if no write is pending.
- Reset mid-write drops `write_en` asynchronously; the bank transaction is abandoned, no retry.

## Test plan
Parameters `TX_W`=8, `MAX_COLS`=16, `DEPTH`=4; `ack` one cycle after `write_en`, `busy` low unless stated.
- Stream `"@.@@\n"` → one write, row 0, col 0, data 8'h0D; `rows_loaded`=1.
- Stream `"@@@@@@@@.@\n"` → write (0, 0, 8'hFF), then (0, 8, 8'h02); `char_ready` low during each write.
- Hold `ack` low 5 cycles and `busy`=1 for 3 cycles after `ack` → `write_en` high exactly until `ack`, then no new write until `ack`=0.
- Stream `"@.\n.@"` with `char_last` on the final `'@'` → writes (0, 0, 8'h01) and (1, 0, 8'h02); `done`=1; `rows_loaded`=2.
- 17 data bytes in one row → two writes; 17th byte dropped; `err`=1. Five rows into `DEPTH`=4 → `err`=1, `rows_loaded`=4.
- `reset`=0 while `write_en`=1 → `write_en` 0 without waiting for clock; after release, IDLE with `done`=0; `start` reloads correctly.
